// File: rtl/aes_key_sch_ctrl_if.sv
// ---------------------------------------------------------------------------
// aes_key_sch_ctrl_if
//   Request / read-port bundle of the AES-256 key-schedule sequencer.
//   master : key consumer (drives start, key, rd_idx[, zeroize])
//   slave  : aes_key_sch_ctrl
//   Signals:
//     start     request expansion of key (honoured only when busy=0)
//     key       256-bit cipher key, w0 = key[255:224] .. w7 = key[31:0]
//     rd_idx    round-key index 0..14
//     rd_key    round key at rd_idx (0 when keys not valid or rd_idx>14)
//     busy      expansion (or zeroisation) in progress
//     key_valid all 15 round keys valid
//     done      single-cycle pulse when an expansion completes
//     zeroize   only with AES_KEY_SCH_ZEROIZE_EN: wipe all round keys
// ---------------------------------------------------------------------------
interface aes_key_sch_ctrl_if;
  logic         start;
  logic [255:0] key;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;
  logic         busy;
  logic         key_valid;
  logic         done;
`ifdef AES_KEY_SCH_ZEROIZE_EN
  logic         zeroize;

  modport master (output start, key, rd_idx, zeroize,
                  input  rd_key, busy, key_valid, done);
  modport slave  (input  start, key, rd_idx, zeroize,
                  output rd_key, busy, key_valid, done);
`else
  modport master (output start, key, rd_idx,
                  input  rd_key, busy, key_valid, done);
  modport slave  (input  start, key, rd_idx,
                  output rd_key, busy, key_valid, done);
`endif
endinterface

// File: rtl/aes_key_sch_ctrl.sv
// ---------------------------------------------------------------------------
// aes_key_sch_ctrl
//   AES-256 key-expansion sequencer. Captures a 256-bit key, runs the
//   key-schedule round function 13 times (one 128-bit round key per step)
//   and serves the 15 round keys through an indexed read port.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous, active-high reset
//     bus  aes_key_sch_ctrl_if.slave (start/key request, read port, status)
//   Parameter:
//     RD_REG 0: rd_key combinational from rd_idx; 1: rd_key registered
//   Optional feature macro:
//     AES_KEY_SCH_ZEROIZE_EN adds bus.zeroize and a ZERO state that wipes
//     one round key per cycle (indices 0..14) and then returns to IDLE.
// ---------------------------------------------------------------------------
module aes_key_sch_ctrl #(
  parameter bit RD_REG = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  aes_key_sch_ctrl_if.slave bus
);

  localparam int         NUM_RK   = 15;
  localparam logic [3:0] LAST_CNT = 4'd14;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,   // also the "keys valid" resting state
    ST_EXPAND = 2'd1
`ifdef AES_KEY_SCH_ZEROIZE_EN
    , ST_ZERO = 2'd2
`endif
  } state_e;

  typedef struct packed {
    logic [255:0] data;
    logic [7:0]   rcon;
  } fn_out_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // S-box = affine map of the GF(2^8) inverse, inverse taken as a^254
  // (254 = 0b1111_1110, so accumulate a^2, a^4 .. a^128); 0 maps to 0.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv;
    logic [7:0] pw;
    inv = 8'h01;
    pw  = a;
    for (int i = 1; i < 8; i++) begin
      pw  = gf_mul(pw, pw);
      inv = gf_mul(inv, pw);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // One key-schedule step over the 8-word window in_data = {w[i-8] .. w[i-1]}.
  // in_mode=1: RotWord+SubWord+Rcon and Rcon advances; in_mode=0: SubWord only.
  // The result window slides by four words: {w[i-4] .. w[i+3]}.
  function automatic fn_out_t key_sch_fun(input logic [255:0] in_data,
                                          input logic [7:0]   in_rcon,
                                          input logic         in_mode);
    fn_out_t      res;
    logic [31:0]  t;
    logic [127:0] nw;
    t = in_mode ? {in_data[23:0], in_data[31:24]} : in_data[31:0];
    t = sub_word(t) ^ (in_mode ? {in_rcon, 24'h0} : 32'h0);
    nw[127:96] = in_data[255:224] ^ t;
    nw[95:64]  = in_data[223:192] ^ nw[127:96];
    nw[63:32]  = in_data[191:160] ^ nw[95:64];
    nw[31:0]   = in_data[159:128] ^ nw[63:32];
    res.data   = {in_data[127:0], nw};
    res.rcon   = in_mode ? xtime(in_rcon) : in_rcon;
    return res;
  endfunction

  state_e       fsm_q, fsm_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [255:0] state_q, state_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [127:0] rk_q [NUM_RK];
  logic [127:0] rk_d [NUM_RK];
  logic         busy_q, busy_d;
  logic         valid_q, valid_d;
  logic         done_q, done_d;
  fn_out_t      fn;

  always_comb begin
    // NOTE: every variable gets a default before any branch, otherwise the
    // unassigned paths would infer latches.
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    rcon_d  = rcon_q;
    rk_d    = rk_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    // Even step counts are the RotWord+Rcon steps.
    fn      = key_sch_fun(state_q, rcon_q, ~cnt_q[0]);

`ifdef AES_KEY_SCH_ZEROIZE_EN
    if (bus.zeroize) begin
      fsm_d   = ST_ZERO;
      cnt_d   = 4'd0;
      state_d = '0;
      rcon_d  = 8'h01;
      busy_d  = 1'b1;
      valid_d = 1'b0;
    end else
`endif
    begin
      case (fsm_q)
        ST_IDLE: begin
          if (bus.start) begin
            fsm_d   = ST_EXPAND;
            rk_d[0] = bus.key[255:128];
            rk_d[1] = bus.key[127:0];
            state_d = bus.key;
            rcon_d  = 8'h01;
            cnt_d   = 4'd2;
            busy_d  = 1'b1;
            valid_d = 1'b0;
          end
        end
        ST_EXPAND: begin
          rk_d[cnt_q] = fn.data[127:0];
          state_d     = fn.data;
          rcon_d      = fn.rcon;
          cnt_d       = cnt_q + 4'd1;
          if (cnt_q == LAST_CNT) begin
            fsm_d   = ST_IDLE;
            busy_d  = 1'b0;
            valid_d = 1'b1;
            done_d  = 1'b1;
          end
        end
`ifdef AES_KEY_SCH_ZEROIZE_EN
        // cnt 0..14 wipes that entry; cnt 15 is the exit cycle.
        ST_ZERO: begin
          if (cnt_q == 4'd15) begin
            fsm_d  = ST_IDLE;
            busy_d = 1'b0;
            cnt_d  = 4'd0;
          end else begin
            rk_d[cnt_q] = '0;
            cnt_d       = cnt_q + 4'd1;
          end
        end
`endif
        default: fsm_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= ST_IDLE;
      cnt_q   <= 4'd0;
      state_q <= '0;
      rcon_q  <= 8'h01;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      // NOTE: the key store is reset on purpose: a reset must leave no key
      // material behind, so it is built from flops rather than a RAM macro.
      for (int i = 0; i < NUM_RK; i++) rk_q[i] <= '0;
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      rcon_q  <= rcon_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      rk_q    <= rk_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.key_valid = valid_q;
  assign bus.done      = done_q;

  generate
    if (RD_REG) begin : g_rd_reg
      logic [127:0] rd_key_d, rd_key_q;
      // Sampled from the next-state view so the register reads 0 from the
      // start edge onward and already holds the new key after the done edge.
      always_comb begin
        rd_key_d = '0;
        if (valid_d && bus.rd_idx != 4'd15) rd_key_d = rk_d[bus.rd_idx];
      end
      always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_key_q <= '0;
        else     rd_key_q <= rd_key_d;
      end
      assign bus.rd_key = rd_key_q;
    end else begin : g_rd_comb
      logic [127:0] rd_key_c;
      always_comb begin
        rd_key_c = '0;
        if (valid_q && bus.rd_idx != 4'd15) rd_key_c = rk_q[bus.rd_idx];
      end
      assign bus.rd_key = rd_key_c;
    end
  endgenerate

endmodule

// File: tb/tb_aes_key_sch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_key_sch_ctrl
//   Two instances (RD_REG=0 and RD_REG=1) receive identical stimulus. The
//   reference is the textbook AES-256 word-array expansion (w[0..59]) using
//   an S-box table generated by the p/q walk over GF(2^8), plus the known
//   FIPS-197 vectors as constants.
// ---------------------------------------------------------------------------
module tb_aes_key_sch_ctrl;

  localparam logic [255:0] KEY1 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_key_sch_ctrl_if bus0 ();
  aes_key_sch_ctrl_if bus1 ();

  aes_key_sch_ctrl #(.RD_REG(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  aes_key_sch_ctrl #(.RD_REG(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int           checks   = 0;
  int           failures = 0;
  logic [7:0]   sbox_t [256];
  logic [127:0] exp_rk [15];
  bit           exp_valid;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box table from the p/q generator: p walks the powers of 3, q the
  // powers of 1/3, so q = p^-1 at every step.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [31:0] sub_word_m(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  task automatic model_expand(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0)
        t = sub_word_m({t[23:0], t[31:24]}) ^ {8'(1 << (i/8 - 1)), 24'h0};
      else if (i % 8 == 4)
        t = sub_word_m(t);
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] exp_read(input logic [3:0] idx);
    if (!exp_valid || idx == 4'd15) return '0;
    return exp_rk[idx];
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] k;
    for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
    return k;
  endfunction

  task automatic drive_start(input logic s, input logic [255:0] key);
    bus0.start = s;  bus1.start = s;
    bus0.key   = key; bus1.key  = key;
  endtask

  task automatic set_idx(input logic [3:0] idx);
    bus0.rd_idx = idx;
    bus1.rd_idx = idx;
  endtask

  // Full expansion; if restart_at > 0 a second start carrying junk is
  // presented during that cycle of the expansion and must be ignored.
  task automatic run_expansion(input logic [255:0] key, input int restart_at,
                               input logic [255:0] junk);
    int edges;
    int busy_cycles;
    @(negedge clk);
    drive_start(1'b1, key);
    @(posedge clk);
    edges = 1;
    busy_cycles = 0;
    @(negedge clk);
    drive_start(1'b0, key);
    exp_valid = 1'b0;
    model_expand(key);
    check("valid_drops_on_start", {bus0.key_valid, bus1.key_valid}, 2'b00);
    while (edges < 40) begin
      if (bus0.done || bus1.done) break;
      if (bus0.busy) begin
        busy_cycles++;
        check("read_zero_while_busy", {bus0.rd_key, bus1.rd_key}, '0);
      end
      drive_start(edges == restart_at, junk);
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    drive_start(1'b0, key);
    exp_valid = 1'b1;
    check("done_edge_count", edges, 14);
    check("busy_cycles", busy_cycles, 13);
    check("done_both", {bus0.done, bus1.done}, 2'b11);
    check("valid_at_done", {bus0.key_valid, bus1.key_valid, bus0.busy, bus1.busy}, 4'b1100);
    check("rd_comb_at_done", bus0.rd_key, exp_read(bus0.rd_idx));
    check("rd_reg_at_done", bus1.rd_key, exp_read(bus1.rd_idx));
    @(negedge clk);
    check("done_single_cycle", {bus0.done, bus1.done}, 2'b00);
  endtask

  task automatic read_sweep(input bit random_order);
    logic [3:0] idx, prev;
    prev = bus0.rd_idx;
    for (int i = 0; i < 16; i++) begin
      idx = random_order ? 4'($urandom_range(0, 15)) : 4'(i);
      @(negedge clk);
      set_idx(idx);
      #1;
      check("rd_comb", bus0.rd_key, exp_read(idx));
      check("rd_reg_lag", bus1.rd_key, exp_read(prev));
      prev = idx;
    end
  endtask

  task automatic read_at(input logic [3:0] idx);
    @(negedge clk);
    set_idx(idx);
    #1;
  endtask

  task automatic reset_mid(input logic [255:0] key);
    @(negedge clk);
    drive_start(1'b1, key);
    @(negedge clk);
    drive_start(1'b0, key);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    exp_valid = 1'b0;
    check("rst_busy", {bus0.busy, bus1.busy}, 2'b00);
    check("rst_valid_done", {bus0.key_valid, bus1.key_valid, bus0.done, bus1.done}, 4'b0000);
    check("rst_rd_key", {bus0.rd_key, bus1.rd_key}, '0);
    @(negedge clk);
    rst = 1'b0;
  endtask

`ifdef AES_KEY_SCH_ZEROIZE_EN
  task automatic zeroize_run();
    int  busy_cycles;
    int  guard;
    bit  saw_done;
    @(negedge clk);
    bus0.zeroize = 1'b1; bus1.zeroize = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus0.zeroize = 1'b0; bus1.zeroize = 1'b0;
    exp_valid   = 1'b0;
    busy_cycles = 0;
    guard       = 0;
    saw_done    = 1'b0;
    while (bus0.busy && guard < 40) begin
      busy_cycles++;
      saw_done = saw_done | bus0.done | bus1.done;
      check("zero_valid_low", {bus0.key_valid, bus1.key_valid}, 2'b00);
      drive_start(guard == 3, rand256());
      @(posedge clk);
      @(negedge clk);
      guard++;
    end
    drive_start(1'b0, '0);
    saw_done = saw_done | bus0.done | bus1.done;
    check("zero_busy_cycles", busy_cycles, 16);
    check("zero_no_done", saw_done, 1'b0);
    check("zero_idle_after", {bus0.busy, bus1.busy, bus0.key_valid, bus1.key_valid}, 4'b0000);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [255:0] k;
    build_sbox();
    exp_valid = 1'b0;
    rst = 1'b1;
    drive_start(1'b0, '0);
    set_idx(4'd0);
`ifdef AES_KEY_SCH_ZEROIZE_EN
    bus0.zeroize = 1'b0; bus1.zeroize = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("reset_busy", {bus0.busy, bus1.busy}, 2'b00);
    check("reset_valid", {bus0.key_valid, bus1.key_valid}, 2'b00);
    check("reset_done", {bus0.done, bus1.done}, 2'b00);
    check("reset_rd_key", {bus0.rd_key, bus1.rd_key}, '0);
    rst = 1'b0;

    // Known-answer expansion.
    set_idx(4'd14);
    run_expansion(KEY1, -1, '0);
    check("kat_rk14", bus0.rd_key, 128'hfe4890d1e6188d0b046df344706c631e);
    read_sweep(1'b0);
    read_at(4'd2);
    check("kat_rk2_w0", bus0.rd_key[127:96], 32'h9ba35411);
    read_at(4'd0);
    check("kat_rk0", bus0.rd_key, 128'h603deb1015ca71be2b73aef0857d7781);
    read_at(4'd15);
    check("idx15_zero", bus0.rd_key, '0);

    // Start pulse 5 cycles into the expansion is ignored.
    set_idx(4'd14);
    run_expansion(KEY1, 5, rand256());
    check("ignored_restart_rk14", bus0.rd_key, 128'hfe4890d1e6188d0b046df344706c631e);

    // Reset in the middle of an expansion, then a fresh expansion.
    reset_mid(rand256());
    read_sweep(1'b1);
    run_expansion(rand256(), -1, '0);
    read_sweep(1'b1);

    // All-zero key while keys are valid.
    run_expansion('0, -1, '0);
    read_at(4'd2);
    check("zero_key_rk2", bus0.rd_key, 128'h62636363626363636263636362636363);

    // Random keys with occasional ignored restarts.
    repeat (5) begin
      k = rand256();
      run_expansion(k, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 12)) : -1, rand256());
      read_sweep(1'b1);
    end

`ifdef AES_KEY_SCH_ZEROIZE_EN
    zeroize_run();
    read_sweep(1'b0);
    run_expansion(rand256(), -1, '0);
    read_sweep(1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
